chien_search_par: RTL and testbench

Parametrised Chien search engine for the Reed-Solomon decoder. It sits between the Berlekamp-Massey stage and the error-value stage. It takes a locator polynomial Λ(x) of degree ≤ T over GF(2^M) and evaluates it at α^j, P points per clock, using internal constant GF multipliers; no external ROMs are used. It reports every exponent j with Λ(α^j)=0, plus the root count and a decodability verdict.

---
 rtl/gf_pkg.sv | 44 ++++
 rtl/chien_lane.sv | 22 ++
 rtl/chien_search_par.sv | 170 +++++++++++++++++
 tb/tb_chien_search_par.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// GF(2^M) arithmetic helpers, field defaults and FSM state type for the Chien search engine.
// Field elements are carried in a GF_W-bit container so one set of functions serves any M <= 16.
package gf_pkg;
    localparam int         GF_M         = 8;
    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;
    localparam int         GF_W         = 16;

    typedef logic [GF_W-1:0] gf_elem_t;
    typedef logic [GF_W:0]   gf_poly_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } chien_state_t;

    function automatic gf_elem_t gf_mul_alpha(input gf_elem_t a, input int m, input gf_poly_t poly);
        gf_poly_t s;
        s = {a, 1'b0};
        if (s[m]) begin
            s = s ^ poly;
        end else begin
            s = s;
        end
        return s[GF_W-1:0];
    endfunction

    // a * alpha^k_exp; k_exp is a constant at every call site, so this folds to XOR trees
    function automatic gf_elem_t gf_mul_const(input gf_elem_t a, input int k_exp, input int m,
                                              input gf_poly_t poly);
        gf_elem_t r;
        int       n;
        n = (1 << m) - 1;
        r = a;
        for (int i = 0; i < (k_exp % n); i++) begin
            r = gf_mul_alpha(r, m, poly);
        end
        return r;
    endfunction

    function automatic gf_elem_t gf_alpha_pow(input int e, input int m, input gf_poly_t poly);
        return gf_mul_const(gf_elem_t'(1), e, m, poly);
    endfunction
endpackage

// File: rtl/chien_lane.sv
// One Chien evaluation lane: combinational sum of R_i * alpha^(i*LANE) over all locator terms.
module chien_lane
    import gf_pkg::*;
#(
    parameter int         M         = GF_M,
    parameter int         T         = 8,
    parameter logic [M:0] PRIM_POLY = GF_PRIM_POLY,
    parameter int         LANE      = 0
)(
    input  logic [(T+1)*M-1:0] r,
    output logic [M-1:0]       s
);
    typedef logic [M-1:0] elem_t;

    // Constant-multiply each running term by the lane offset and accumulate in GF(2^M)
    always_comb begin
        s = '0;
        for (int i = 0; i <= T; i++) begin
            s = s ^ elem_t'(gf_mul_const(gf_elem_t'(r[i*M +: M]), i * LANE, M, gf_poly_t'(PRIM_POLY)));
        end
    end
endmodule

// File: rtl/chien_search_par.sv
// Parallel Chien search: scans P points of Lambda(alpha^j) per clock and collects the roots.
// Optional CHIEN_EARLY_STOP_EN ends the scan once the root count reaches the locator degree.
module chien_search_par
    import gf_pkg::*;
#(
    parameter int         M         = GF_M,
    parameter logic [M:0] PRIM_POLY = GF_PRIM_POLY,
    parameter int         T         = 8,
    parameter int         P         = 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lc_valid,
    output logic                   lc_ready,
    input  logic [(T+1)*M-1:0]     lc,
    output logic                   done,
    output logic [$clog2(T+1)-1:0] root_cnt,
    output logic [T*M-1:0]         roots,
    output logic                   deg_ok,
    output logic                   overflow
);
    localparam int N  = (1 << M) - 1;
    localparam int JW = $clog2(N + P);
    localparam int CW = $clog2(T + 1);

    typedef logic [M-1:0]  elem_t;
    typedef logic [JW-1:0] jidx_t;
    typedef logic [CW-1:0] cnt_t;

    chien_state_t       state_r;
    logic [(T+1)*M-1:0] r_r;
    logic [(T+1)*M-1:0] r_next_s;
    logic [P*M-1:0]     lane_s;
    logic [P*M-1:0]     s_r;
    jidx_t              base_r;
    jidx_t              jb_r;
    logic               s_valid_r;
    cnt_t               deg_r;
    cnt_t               deg_s;
    cnt_t               cnt_next_s;
    logic [T*M-1:0]     roots_next_s;
    logic               ovf_next_s;
    logic               deg_ok_next_s;
    logic               scan_last_s;
    logic               stop_s;

    assign lc_ready    = (state_r == IDLE);
    assign scan_last_s = (int'(base_r) + P) >= N;

    for (genvar p = 0; p < P; p++) begin : g_lane
        chien_lane #(.M(M), .T(T), .PRIM_POLY(PRIM_POLY), .LANE(p)) u_lane (
            .r (r_r),
            .s (lane_s[p*M +: M])
        );
    end

    // Advancing every term by alpha^(i*P) moves the whole evaluation window forward by P points
    for (genvar i = 0; i <= T; i++) begin : g_step
        assign r_next_s[i*M +: M] =
            elem_t'(gf_mul_const(gf_elem_t'(r_r[i*M +: M]), i * P, M, gf_poly_t'(PRIM_POLY)));
    end

    // Locator degree: index of the highest non-zero coefficient
    always_comb begin
        deg_s = '0;
        for (int i = 1; i <= T; i++) begin
            if (lc[i*M +: M] != '0) begin
                deg_s = cnt_t'(i);
            end else begin
                deg_s = deg_s;
            end
        end
    end

    // Compare stage: append zero-valued lanes in ascending j, masking points past N-1
    always_comb begin
        jidx_t j;
        j            = '0;
        cnt_next_s   = root_cnt;
        roots_next_s = roots;
        ovf_next_s   = overflow;
        for (int p = 0; p < P; p++) begin
            j = jb_r + jidx_t'(p);
            if (s_valid_r && (s_r[p*M +: M] == '0) && (j < jidx_t'(N))) begin
                if (cnt_next_s < cnt_t'(T)) begin
                    roots_next_s[cnt_next_s*M +: M] = j[M-1:0];
                    cnt_next_s = cnt_next_s + cnt_t'(1);
                end else begin
                    ovf_next_s = 1'b1;
                end
            end else begin
                ovf_next_s = ovf_next_s;
            end
        end
        deg_ok_next_s = (cnt_next_s == deg_r) && (deg_r != '0) && !ovf_next_s;
    end

`ifdef CHIEN_EARLY_STOP_EN
    assign stop_s = s_valid_r && (deg_r != '0) && (cnt_next_s == deg_r) && !ovf_next_s;
`else
    assign stop_s = 1'b0;
`endif

    // Control FSM, scan registers and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            r_r       <= '0;
            s_r       <= '0;
            base_r    <= '0;
            jb_r      <= '0;
            s_valid_r <= 1'b0;
            deg_r     <= '0;
            done      <= 1'b0;
            root_cnt  <= '0;
            roots     <= '0;
            deg_ok    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    s_valid_r <= 1'b0;
                    if (lc_valid) begin
                        r_r      <= lc;
                        deg_r    <= deg_s;
                        base_r   <= '0;
                        root_cnt <= '0;
                        roots    <= '0;
                        overflow <= 1'b0;
                        deg_ok   <= 1'b0;
                        state_r  <= SCAN;
                    end
                end
                SCAN: begin
                    root_cnt <= cnt_next_s;
                    roots    <= roots_next_s;
                    overflow <= ovf_next_s;
                    if (stop_s) begin
                        deg_ok    <= 1'b1;
                        done      <= 1'b1;
                        s_valid_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        s_r       <= lane_s;
                        jb_r      <= base_r;
                        s_valid_r <= 1'b1;
                        r_r       <= r_next_s;
                        base_r    <= base_r + jidx_t'(P);
                        if (scan_last_s) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    root_cnt  <= cnt_next_s;
                    roots     <= roots_next_s;
                    overflow  <= ovf_next_s;
                    deg_ok    <= deg_ok_next_s;
                    done      <= 1'b1;
                    s_valid_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chien_search_par.sv
// Directed bench for chien_search_par: a P=1 and a P=4 instance, GF(2^8) with 0x11D.
`timescale 1ns/1ps
module tb_chien_search_par;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, a_done, a_deg_ok, a_ovf;
    logic [71:0] a_lc;
    logic [3:0]  a_cnt;
    logic [63:0] a_roots;
    logic        b_valid, b_ready, b_done, b_deg_ok, b_ovf;
    logic [71:0] b_lc;
    logic [3:0]  b_cnt;
    logic [63:0] b_roots;
    int          checks = 0;
    int          errors = 0;

`ifdef CHIEN_EARLY_STOP_EN
    localparam int LAT_C2 = 255;
    localparam int LAT_C3 = 173;
    localparam int LAT_C4 = 248;
`else
    localparam int LAT_C2 = 257;
    localparam int LAT_C3 = 257;
    localparam int LAT_C4 = 257;
`endif
    localparam logic [71:0] POLY_C2   = 72'h87_7C01;
    localparam logic [71:0] POLY_C3   = 72'h01_0101;
    localparam logic [71:0] POLY_C4   = 72'hB9_0FA0_01;
    localparam logic [69:0] RES_C2    = {4'd2, 64'h0000_0000_0000_FCF5, 1'b1, 1'b0};
    localparam logic [69:0] RES_C3    = {4'd2, 64'h0000_0000_0000_AA55, 1'b1, 1'b0};
    localparam logic [69:0] RES_C4    = {4'd3, 64'h0000_0000_00F5_EBE1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    chien_search_par #(.M(8), .PRIM_POLY(9'h11D), .T(8), .P(1)) dut_a (
        .clk(clk), .reset(reset), .lc_valid(a_valid), .lc_ready(a_ready), .lc(a_lc),
        .done(a_done), .root_cnt(a_cnt), .roots(a_roots), .deg_ok(a_deg_ok), .overflow(a_ovf)
    );

    chien_search_par #(.M(8), .PRIM_POLY(9'h11D), .T(8), .P(4)) dut_b (
        .clk(clk), .reset(reset), .lc_valid(b_valid), .lc_ready(b_ready), .lc(b_lc),
        .done(b_done), .root_cnt(b_cnt), .roots(b_roots), .deg_ok(b_deg_ok), .overflow(b_ovf)
    );

    // Called at a negedge; returns with the bench at the negedge where done is high (lat = -1 on timeout)
    task automatic run_poly(input bit use_b, input logic [71:0] poly, output int lat);
        int edges;
        checks++;
        if ((use_b ? b_ready : a_ready) !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: got %b expected 1", use_b ? b_ready : a_ready);
        end
        if (use_b) begin
            b_lc = poly; b_valid = 1'b1;
        end else begin
            a_lc = poly; a_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        edges = 0;
        while ((use_b ? b_done : a_done) !== 1'b1 && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        lat = ((use_b ? b_done : a_done) === 1'b1) ? edges + 1 : -1;
    endtask

    task automatic test_reset();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_lc = '0; b_lc = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ready, b_ready, a_done, b_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1100", {a_ready, b_ready, a_done, b_done});
        end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs_a: got %h expected 0", {a_cnt, a_roots, a_deg_ok, a_ovf});
        end
        checks++;
        if ({b_cnt, b_roots, b_deg_ok, b_ovf} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs_b: got %h expected 0", {b_cnt, b_roots, b_deg_ok, b_ovf});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_deg0();
        int lat;
        run_poly(1'b0, 72'h1, lat);
        checks++;
        if (lat !== 257) begin errors++; $display("FAIL deg0_latency: got %0d expected 257", lat); end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== 70'd0) begin
            errors++;
            $display("FAIL deg0_result: got %h expected 0", {a_cnt, a_roots, a_deg_ok, a_ovf});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_poly(1'b0, POLY_C2, lat);
        checks++;
        if (lat !== LAT_C2) begin errors++; $display("FAIL c2_latency: got %0d expected %0d", lat, LAT_C2); end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== RES_C2) begin
            errors++;
            $display("FAIL c2_result: got %h expected %h", {a_cnt, a_roots, a_deg_ok, a_ovf}, RES_C2);
        end
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL ready_with_done: got %b expected 1", a_ready); end
        run_poly(1'b0, POLY_C3, lat);
        checks++;
        if (lat !== LAT_C3) begin errors++; $display("FAIL c3_latency: got %0d expected %0d", lat, LAT_C3); end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== RES_C3) begin
            errors++;
            $display("FAIL c3_result: got %h expected %h", {a_cnt, a_roots, a_deg_ok, a_ovf}, RES_C3);
        end
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", a_done); end
    endtask

    task automatic test_degree3();
        int lat;
        run_poly(1'b0, POLY_C4, lat);
        checks++;
        if (lat !== LAT_C4) begin errors++; $display("FAIL c4_latency: got %0d expected %0d", lat, LAT_C4); end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== RES_C4) begin
            errors++;
            $display("FAIL c4_result: got %h expected %h", {a_cnt, a_roots, a_deg_ok, a_ovf}, RES_C4);
        end
    endtask

    task automatic test_parallel();
        int lat;
        run_poly(1'b1, POLY_C2, lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL p4_c2_latency: got %0d expected 66", lat); end
        checks++;
        if ({b_cnt, b_roots, b_deg_ok, b_ovf} !== RES_C2) begin
            errors++;
            $display("FAIL p4_c2_result: got %h expected %h", {b_cnt, b_roots, b_deg_ok, b_ovf}, RES_C2);
        end
        run_poly(1'b1, 72'h0201, lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL p4_last_latency: got %0d expected 66", lat); end
        checks++;
        if ({b_cnt, b_roots, b_deg_ok, b_ovf} !== {4'd1, 64'h00FE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL p4_last_result: got %h expected %h", {b_cnt, b_roots, b_deg_ok, b_ovf},
                     {4'd1, 64'h00FE, 1'b1, 1'b0});
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_poly(1'b0, 72'h0, lat);
        checks++;
        if (lat !== 257) begin errors++; $display("FAIL zero_latency: got %0d expected 257", lat); end
        checks++;
        if ({a_cnt, a_roots, a_deg_ok, a_ovf} !== {4'd8, 64'h0706_0504_0302_0100, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_result: got %h expected %h", {a_cnt, a_roots, a_deg_ok, a_ovf},
                     {4'd8, 64'h0706_0504_0302_0100, 1'b0, 1'b1});
        end
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        a_lc = 72'h0; a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (99) @(negedge clk);
        checks++;
        if ({a_cnt, a_ovf, a_ready} !== {4'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_scan_state: got %b expected %b", {a_cnt, a_ovf, a_ready}, {4'd8, 1'b1, 1'b0});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_done, a_cnt, a_roots, a_deg_ok, a_ovf} !== {1'b1, 71'd0}) begin
            errors++;
            $display("FAIL mid_scan_reset: got %h expected %h",
                     {a_ready, a_done, a_cnt, a_roots, a_deg_ok, a_ovf}, {1'b1, 71'd0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (a_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_done_after_abort: got pulses %0d ready %b expected 0 and 1", pulses, a_ready);
        end
    endtask

    initial begin
        test_reset();
        test_deg0();
        test_back_to_back();
        test_degree3();
        test_parallel();
        test_overflow();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
